// File: rtl/lcd_bus_sequencer_if.sv
// Bundles the two byte-write requester handshakes and the LCD bus pins
// driven by lcd_bus_sequencer.
interface lcd_bus_sequencer_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic       rs;
  logic       e;
  logic [7:0] data;
  logic       init_done;
  logic       busy;

  modport master (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, rs, e, data, init_done, busy
  );

  modport slave (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, rs, e, data, init_done, busy
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// Owns an HD44780-style 8-bit LCD bus: runs the power-on init sequence, then
// shares the bus round-robin between two byte-write requesters.
module lcd_bus_sequencer #(
  parameter int POR_WAIT_CYC = 2000000,
  parameter int SETUP_CYC    = 8,
  parameter int E_HIGH_CYC   = 32,
  parameter int CMD_WAIT_CYC = 5000,
  parameter int CLR_WAIT_CYC = 200000
) (
  input logic                  clk,
  input logic                  rst,
  lcd_bus_sequencer_if.master  bus
);

  // A zero-length phase still occupies one cycle.
  localparam int POR_LEN = (POR_WAIT_CYC < 1) ? 1 : POR_WAIT_CYC;
  localparam int SU_LEN  = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
  localparam int EH_LEN  = (E_HIGH_CYC   < 1) ? 1 : E_HIGH_CYC;
  localparam int CMD_LEN = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
  localparam int CLR_LEN = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;

  localparam int MAX_A   = (POR_LEN > CLR_LEN) ? POR_LEN : CLR_LEN;
  localparam int MAX_B   = (MAX_A > CMD_LEN) ? MAX_A : CMD_LEN;
  localparam int MAX_C   = (MAX_B > SU_LEN) ? MAX_B : SU_LEN;
  localparam int MAX_LEN = (MAX_C > EH_LEN) ? MAX_C : EH_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_LEN - 1);
  localparam logic [CNT_W-1:0] SU_LAST  = CNT_W'(SU_LEN - 1);
  localparam logic [CNT_W-1:0] EH_LAST  = CNT_W'(EH_LEN - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_LEN - 1);

  typedef enum logic [2:0] {
    S_POR_WAIT,
    S_INIT_LOAD,
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_last;
  logic             r_init_done;
  logic             r_rs;
  logic             r_e;
  logic [7:0]       r_data;
  logic             w_ack0;
  logic             w_ack1;
  logic [CNT_W-1:0] w_wait_last;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long settle time.
  function automatic logic is_long_cmd(input logic rs_i, input logic [7:0] d);
    return !rs_i && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

  assign w_wait_last = is_long_cmd(r_rs, r_data) ? CLR_LAST : CMD_LAST;

  always_comb begin
    w_next = r_state;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    case (r_state)
      S_POR_WAIT:  if (r_cnt == POR_LAST) w_next = S_INIT_LOAD;
      S_INIT_LOAD: w_next = S_SETUP;
      S_IDLE: begin
        // r_last holds the previous grantee; on contention the other side wins.
        if (r_init_done) begin
          if (bus.req1 && (!bus.req0 || !r_last)) begin
            w_ack1 = 1'b1;
            w_next = S_SETUP;
          end else if (bus.req0) begin
            w_ack0 = 1'b1;
            w_next = S_SETUP;
          end
        end
      end
      S_SETUP:     if (r_cnt == SU_LAST) w_next = S_E_HIGH;
      S_E_HIGH:    if (r_cnt == EH_LAST) w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == w_wait_last)
          w_next = (r_init_done || r_idx == 2'd3) ? S_IDLE : S_INIT_LOAD;
      end
      default:     w_next = S_POR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_POR_WAIT;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_last      <= 1'b0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_e         <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state != S_IDLE)
        r_cnt <= r_cnt + CNT_W'(1);
      r_e <= (w_next == S_E_HIGH);
      if (r_state == S_INIT_LOAD) begin
        r_rs   <= 1'b0;
        r_data <= init_byte(r_idx);
      end else if (w_ack0) begin
        r_rs   <= bus.rs0;
        r_data <= bus.data0;
        r_last <= 1'b0;
      end else if (w_ack1) begin
        r_rs   <= bus.rs1;
        r_data <= bus.data1;
        r_last <= 1'b1;
      end
      if (r_state == S_WAIT && w_next != S_WAIT && !r_init_done) begin
        if (r_idx == 2'd3) r_init_done <= 1'b1;
        else               r_idx       <= r_idx + 2'd1;
      end
    end
  end

  assign bus.ack0      = w_ack0;
  assign bus.ack1      = w_ack1;
  assign bus.rs        = r_rs;
  assign bus.e         = r_e;
  assign bus.data      = r_data;
  assign bus.init_done = r_init_done;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Owns the 8-bit HD44780-style character LCD bus (rs, e, data) at the top level.
- After reset it runs the power-on initialisation sequence, then shares the bus between two byte-write requesters: req0 is the lock-state/message writer and req1 is the keypad echo writer.
- Generates all enable-pulse timing and post-command busy delays, so requesters only hand over {rs, byte} pairs.

Parameters:
- POR_WAIT_CYC, 2000000, clk cycles to wait after reset before the first init command.
- SETUP_CYC, 8, cycles rs/data are stable with e=0 before e rises.
- E_HIGH_CYC, 32, cycles e is held high.
- CMD_WAIT_CYC, 5000, cycles after e falls for a normal command or a data byte.
- CLR_WAIT_CYC, 200000, cycles after e falls for clear (0x01) or home (0x02/0x03) commands, i.e. rs=0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 write request; held until ack0
- rs0  in  1  requester 0 register select (0=command, 1=data)
- data0  in  8  requester 0 byte
- ack0  out  1  one-cycle grant/capture pulse for requester 0
- req1  in  1  requester 1 write request; held until ack1
- rs1  in  1  requester 1 register select
- data1  in  8  requester 1 byte
- ack1  out  1  one-cycle grant/capture pulse for requester 1
- rs  out  1  LCD register select
- e  out  1  LCD enable
- data  out  8  LCD data bus
- init_done  out  1  high once the init sequence completes; stays high until reset
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, active-high): rs=0, e=0, data=0x00, ack0=ack1=0, init_done=0, busy=1, state=POR_WAIT, cycle counter=0, init index=0, round-robin pointer=0 (requester 1 has priority on the first contention). Asserting rst in any state aborts the current transfer immediately and restarts from POR_WAIT.
- States: POR_WAIT, INIT_LOAD, IDLE, SETUP, E_HIGH, WAIT.
- POR_WAIT: counts POR_WAIT_CYC cycles, then goes to INIT_LOAD.
- INIT_LOAD: loads init byte[idx] with rs=0. The sequence is 0x38, 0x0C, 0x06, 0x01 (idx 0..3). Next state is SETUP.
- SETUP: drives rs/data; e=0 for SETUP_CYC cycles, then goes to E_HIGH.
- E_HIGH: e=1 for E_HIGH_CYC cycles. rs/data are unchanged. Then goes to WAIT with e=0 on the first WAIT cycle.
- WAIT: holds rs/data. Wait length is CLR_WAIT_CYC if rs=0 and data is 0x01, 0x02 or 0x03; otherwise it is CMD_WAIT_CYC.
  - During init with idx<3: idx++ and go to INIT_LOAD.
  - During init with idx=3: set init_done=1 and go to IDLE.
  - After init: go to IDLE.
- IDLE: busy=0. Requests are sampled only in IDLE with init_done=1; requests raised earlier are ignored (no ack) until then.
  - Only one request: grant it.
  - Both requests: grant the requester that was not granted last. The pointer is updated on every grant.
  - On the grant cycle: ackN=1 for exactly one cycle, {rsN, dataN} are captured into the rs/data registers, and the next state is SETUP. Bus outputs change on the following clock edge.
- Requester protocol: the requester must hold req/rs/data stable until it sees ack. It drops req or presents its next byte in the cycle after ack. If req is still high in the IDLE cycle after a transfer, that counts as a new request.
- e is never high outside E_HIGH. data/rs never change while e=1 or during WAIT.
- Minimum transfer length: 1 (grant) + SETUP_CYC + E_HIGH_CYC + wait cycles; back-to-back grants are separated by at least that.
- Counters must be wide enough for max(POR_WAIT_CYC, CLR_WAIT_CYC) (clog2). A parameter value of 0 is treated as 1 cycle.

Test Plan (POR_WAIT_CYC=10, SETUP_CYC=2, E_HIGH_CYC=4, CMD_WAIT_CYC=8, CLR_WAIT_CYC=20):
- Reset then idle: e pulses exactly 4 times, each 4 cycles wide, with data 0x38, 0x0C, 0x06, 0x01 (rs=0). init_done rises 20 cycles after the 4th e falls. req0 held high during init gets no ack before init_done.
- After init: req0=1, rs0=1, data0=0x41. Required: ack0 one cycle; 2 cycles later e=1 with rs=1, data=0x41 for 4 cycles; busy returns low 8 cycles after e falls.
- req0 and req1 held continuously with data 0xA0 and 0xB1: grants alternate 1,0,1,0 (pointer reset value is 0). Bytes appear on data in the order B1, A0, B1, A0. No two acks fall within one transfer length.
- Requester 1 sends rs=0, data=0x01: WAIT lasts 20 cycles. Requester 1 sends rs=1, data=0x01: WAIT lasts 8 cycles.
- Assert rst while e=1 during a data write: next cycle e=0, data=0x00, init_done=0. The init sequence restarts after 10 cycles, and the interrupted requester is not acked again until after init.
- Single requester with req held high across a transfer: it gets a second ack in the first IDLE cycle after the WAIT state ends, and ack is never high two consecutive cycles.
